// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between the execute stage and the multiply/divide unit
//
// Purpose: carries the one-cycle request (start, op, A, B) into md_unit and
//          brings busy and the HI/LO registers back out.
// Signals:
//   start  request strobe, qualifies op/A/B
//   op     3-bit opcode (0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo)
//   A, B   32-bit rs / rt operands
//   busy   operation in flight
//   HI, LO 32-bit result registers
// Modports: master = execute stage side, slave = md_unit side.

interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, op, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: accepts mult/multu (5 busy cycles) and div/divu (10 busy cycles)
//          requests, plus single-edge mthi/mtlo writes while idle. Results are
//          computed only from operands latched at acceptance.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    md_unit_if.slave: start/op/A/B in, busy/HI/LO out

module md_unit (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_is_mul;
    logic        w_div_zero;

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // ordinary product equal to the two's-complement signed product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod   = (r_op == OP_MULT) ? w_prod_s : w_prod_u;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps back to
    // 0x80000000 without relying on simulator overflow behaviour.
    assign w_a_neg    = (r_op == OP_DIV) && r_a[31];
    assign w_b_neg    = (r_op == OP_DIV) && r_b[31];
    assign w_a_mag    = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_b_mag    = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_div_zero = (r_b == 32'd0);
    // Substitute divisor keeps the divider X-free; its result is discarded.
    assign w_den      = w_div_zero ? 32'd1 : w_b_mag;
    assign w_uq       = w_a_mag / w_den;
    assign w_ur       = w_a_mag % w_den;
    assign w_q        = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
    assign w_r        = w_a_neg ? (~w_ur + 32'd1) : w_ur;

    assign w_is_mul   = (r_op == OP_MULT) || (r_op == OP_MULTU);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                r_a     <= bus.A;
                                r_b     <= bus.B;
                                r_op    <= bus.op;
                                r_cnt   <= MUL_CYCLES;
                                r_state <= ST_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_a     <= bus.A;
                                r_b     <= bus.B;
                                r_op    <= bus.op;
                                r_cnt   <= DIV_CYCLES;
                                r_state <= ST_RUN;
                            end
                            OP_MTHI: r_hi <= bus.A;
                            OP_MTLO: r_lo <= bus.A;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // start is deliberately not looked at here: nothing queues.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_IDLE;
                        if (w_is_mul) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (!w_div_zero) begin
                            r_hi <= w_r;
                            r_lo <= w_q;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit

module tb_md_unit;
    logic clk;
    logic reset;

    md_unit_if bus ();

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles and, when busy falls, pops the expected
    // completion and compares HI, LO and busy length.
    int busy_cycles = 0;
    bit prev_busy   = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy === 1'b1) begin
                busy_cycles++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_completion: got busy fall expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check32({e.name, "_hi"}, bus.HI, e.hi);
                    check32({e.name, "_lo"}, bus.LO, e.lo);
                    check_int({e.name, "_busy_cycles"}, busy_cycles, e.cycles);
                end
                busy_cycles = 0;
            end
            prev_busy = (bus.busy === 1'b1);
        end
    end

    task automatic expect_op(input string name, input logic [31:0] hi, input logic [31:0] lo, input int cycles);
        exp_t e;
        e.hi = hi; e.lo = lo; e.cycles = cycles; e.name = name;
        exp_q.push_back(e);
    endtask

    // Called just after a negedge; the request is taken on the next posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns on the first negedge that sees busy low (first idle cycle).
    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got busy=1 after 40 cycles expected busy=0", name);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;

        // Reset overrides a simultaneous mthi request.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.A     = 32'hDEAD_BEEF;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check32("reset_hi", bus.HI, 32'h0);
        check32("reset_lo", bus.LO, 32'h0);
        check32("reset_busy", {31'd0, bus.busy}, 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Signed multiply -2 * 3.
        expect_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle("mult_neg");

        // Unsigned multiply 0xFFFFFFFF squared.
        expect_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("multu_max");

        // Signed divide -7 / 2: quotient -3, remainder -1.
        expect_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_neg");

        // Divide by zero leaves HI/LO alone.
        expect_op("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd3, 32'd7, 32'd0);
        wait_idle("divu_zero");

        // Most-negative / -1.
        expect_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        // Unsigned divide with high-bit dividend.
        expect_op("divu_big", 32'h0000_0001, 32'h4000_0000, 10);
        issue(3'd3, 32'h8000_0001, 32'd2);
        wait_idle("divu_big");

        // mthi / mtlo while idle.
        issue(3'd4, 32'h0000_1234, 32'd0);
        @(negedge clk);
        check32("mthi_hi", bus.HI, 32'h0000_1234);
        check32("mthi_lo_held", bus.LO, 32'h4000_0000);
        check32("mthi_busy", {31'd0, bus.busy}, 32'h0);
        issue(3'd5, 32'h0000_5555, 32'd0);
        @(negedge clk);
        check32("mtlo_lo", bus.LO, 32'h0000_5555);
        check32("mtlo_hi_held", bus.HI, 32'h0000_1234);

        // No-op opcodes change nothing.
        issue(3'd6, 32'hAAAA_AAAA, 32'd1);
        issue(3'd7, 32'hBBBB_BBBB, 32'd1);
        @(negedge clk);
        check32("nop_hi", bus.HI, 32'h0000_1234);
        check32("nop_lo", bus.LO, 32'h0000_5555);
        check32("nop_busy", {31'd0, bus.busy}, 32'h0);

        // mtlo/mthi during a running mult are dropped; A/B wiggle mid-run.
        expect_op("mult_ignore_mt", 32'h0000_0000, 32'd42, 5);
        issue(3'd0, 32'd7, 32'd6);
        @(negedge clk);
        issue(3'd5, 32'h0000_AAAA, 32'd0);
        @(negedge clk);
        issue(3'd4, 32'h0000_BBBB, 32'd0);
        bus.A = 32'h1111_1111;
        bus.B = 32'h2222_2222;
        wait_idle("mult_ignore_mt");

        // Back-to-back: div accepted in the first idle cycle.
        expect_op("b2b_mult", 32'h0000_0000, 32'd12, 5);
        issue(3'd0, 32'd3, 32'd4);
        wait_idle("b2b_mult");
        expect_op("b2b_div", 32'd2, 32'd14, 10);
        issue(3'd2, 32'd100, 32'd7);
        @(negedge clk);
        check32("b2b_busy_gap", {31'd0, bus.busy}, 32'h1);
        wait_idle("b2b_div");

        // Reset at RUN cycle 4 of a divide.
        expect_op("reset_abort", 32'h0, 32'h0, 4);
        issue(3'd2, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check32("abort_busy", {31'd0, bus.busy}, 32'h0);
        check32("abort_hi", bus.HI, 32'h0);
        check32("abort_lo", bus.LO, 32'h0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check32("abort_late_hi", bus.HI, 32'h0);
        check32("abort_late_lo", bus.LO, 32'h0);

        repeat (2) @(negedge clk);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
